// File: rtl/pixel_collector_pkg.sv
// Shared widths and FIFO entry type for the pixel collector.
// Imported by the interface, the FIFO and the top level.
package pixel_collector_pkg;
    localparam int PIX_W  = 4;
    localparam int ADDR_W = 19;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } entry_t;
endpackage

// File: rtl/pixel_collector_if.sv
// Memory write port of the pixel collector.
// Writes are held until mem_we && mem_ready.
interface pixel_collector_if;
    import pixel_collector_pkg::*;

    logic [ADDR_W-1:0] mem_addr;
    logic [PIX_W-1:0]  mem_data;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        input  mem_ready
    );

    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/pixel_fifo.sv
// Synchronous per-solver FIFO; DEPTH must be a power of two.
// A push into a full FIFO is taken only when a pop happens that cycle.
module pixel_fifo
    import pixel_collector_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   push,
    input  logic   pop,
    input  entry_t wr,
    output entry_t rd,
    output logic   full,
    output logic   empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t        mem [DEPTH];
    logic [AW:0]   wp;
    logic [AW:0]   rp;
    logic          do_push;
    logic          do_pop;

    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) &&
                     (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd      = mem[rp[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wp[AW-1:0]] <= wr;
    end
endmodule

// File: rtl/pixel_collector.sv
// Gathers pixels from interleaved row solvers into one memory write port.
// Optional PIXEL_COLLECTOR_STATS_EN adds pixel_count and drop_count.
module pixel_collector
    import pixel_collector_pkg::*;
#(
    parameter int NUM_SOLVERS = 1,
    parameter int NUM_COLUMNS = 640,
    parameter int NUM_ROWS    = 480,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         frame_start,
    input  logic [NUM_SOLVERS-1:0]       solver_valid,
    input  logic [PIX_W*NUM_SOLVERS-1:0] solver_data,
    input  logic [NUM_SOLVERS-1:0]       solver_done,
    pixel_collector_if.master            mem,
    output logic                         overflow,
    output logic                         frame_done
`ifdef PIXEL_COLLECTOR_STATS_EN
    ,
    output logic [ADDR_W-1:0]            pixel_count,
    output logic [15:0]                  drop_count
`endif
);
    localparam int SW = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(NUM_COLUMNS - 1);
    localparam logic [ADDR_W-1:0] ROW_LIM  = ADDR_W'(NUM_ROWS);
    localparam logic [ADDR_W-1:0] ROW_STEP =
        ADDR_W'((NUM_SOLVERS - 1) * NUM_COLUMNS + 1);

    logic                   clear;
    logic [NUM_SOLVERS-1:0] adv;
    logic [NUM_SOLVERS-1:0] drop;
    logic [NUM_SOLVERS-1:0] pop;
    logic [NUM_SOLVERS-1:0] full;
    logic [NUM_SOLVERS-1:0] empty;
    entry_t                 head [NUM_SOLVERS];
    logic [SW-1:0]          rr_ptr;
    logic [SW-1:0]          grant_idx;
    logic [SW-1:0]          next_ptr;
    logic [SW:0]            cand;
    logic                   grant_any;
    logic                   load_en;
    logic                   we_q;
    entry_t                 out_q;

    assign clear   = reset || frame_start;
    assign load_en = !we_q || mem.mem_ready;

    for (genvar i = 0; i < NUM_SOLVERS; i++) begin : g_solver
        logic [ADDR_W-1:0] col;
        logic [ADDR_W-1:0] row;
        logic [ADDR_W-1:0] addr;
        entry_t            wr;

        // Pulses past the last owned row are ignored, never counted as drops.
        assign adv[i]  = solver_valid[i] && (row < ROW_LIM);
        assign drop[i] = adv[i] && full[i] && !pop[i];
        assign wr      = '{addr: addr,
                           data: solver_data[PIX_W*i +: PIX_W]};

        always_ff @(posedge clock) begin
            if (clear) begin
                col  <= '0;
                row  <= ADDR_W'(i);
                addr <= ADDR_W'(i * NUM_COLUMNS);
            end else if (adv[i]) begin
                if (col == LAST_COL) begin
                    col  <= '0;
                    row  <= row + ADDR_W'(NUM_SOLVERS);
                    addr <= addr + ROW_STEP;
                end else begin
                    col  <= col + 1'b1;
                    addr <= addr + 1'b1;
                end
            end
        end

        pixel_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (clear),
            .push  (adv[i]),
            .pop   (pop[i]),
            .wr    (wr),
            .rd    (head[i]),
            .full  (full[i]),
            .empty (empty[i])
        );
    end

    // Scan downward so the first non-empty FIFO at or after rr_ptr wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            cand = {1'b0, rr_ptr} + (SW+1)'(k);
            if (cand >= (SW+1)'(NUM_SOLVERS))
                cand = cand - (SW+1)'(NUM_SOLVERS);
            if (!empty[cand[SW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[SW-1:0];
            end
        end
    end

    assign next_ptr =
        ({1'b0, grant_idx} == (SW+1)'(NUM_SOLVERS - 1)) ?
        '0 : grant_idx + 1'b1;

    always_comb begin
        pop = '0;
        if (load_en && grant_any && !clear)
            pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            we_q       <= 1'b0;
            out_q      <= '0;
            rr_ptr     <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (load_en) begin
                we_q <= grant_any;
                if (grant_any) begin
                    out_q  <= head[grant_idx];
                    rr_ptr <= next_ptr;
                end
            end
            if (|drop) overflow <= 1'b1;
            frame_done <= (&solver_done) && (&empty) && !we_q;
        end
    end

    assign mem.mem_addr = out_q.addr;
    assign mem.mem_data = out_q.data;
    assign mem.mem_we   = we_q;

`ifdef PIXEL_COLLECTOR_STATS_EN
    logic [16:0] drop_sum;

    assign drop_sum = {1'b0, drop_count} + 17'($countones(drop));

    always_ff @(posedge clock) begin
        if (clear) begin
            pixel_count <= '0;
            drop_count  <= '0;
        end else begin
            if (we_q && mem.mem_ready)
                pixel_count <= pixel_count + 1'b1;
            drop_count <= drop_sum[16] ? '1 : drop_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_pixel_collector.sv
// Directed and randomized bench for pixel_collector (1-solver and 2-solver builds).
// Expected writes come from a row/column address model and per-solver queues.
module tb_pixel_collector;
    logic       clock = 1'b0;
    logic       reset;
    logic       fs_a, fs_b;
    logic [0:0] v_a, done_a;
    logic [3:0] d_a;
    logic [1:0] v_b, done_b;
    logic [7:0] d_b;
    logic       ov_a, fd_a, ov_b, fd_b;
`ifdef PIXEL_COLLECTOR_STATS_EN
    logic [18:0] pc_a, pc_b;
    logic [15:0] dc_a, dc_b;
`endif

    int checks = 0;
    int passed = 0;
    int failed = 0;

    logic [22:0] obs_a[$];
    logic [22:0] obs_b[$];
    logic [22:0] exp0[$];
    logic [22:0] exp1[$];

    always #5 clock = ~clock;

    pixel_collector_if if_a ();
    pixel_collector_if if_b ();

    pixel_collector #(
        .NUM_SOLVERS (1),
        .NUM_COLUMNS (4),
        .NUM_ROWS    (2),
        .FIFO_DEPTH  (4)
    ) dut_a (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (fs_a),
        .solver_valid (v_a),
        .solver_data  (d_a),
        .solver_done  (done_a),
        .mem          (if_a),
        .overflow     (ov_a),
        .frame_done   (fd_a)
`ifdef PIXEL_COLLECTOR_STATS_EN
        ,
        .pixel_count  (pc_a),
        .drop_count   (dc_a)
`endif
    );

    pixel_collector #(
        .NUM_SOLVERS (2),
        .NUM_COLUMNS (4),
        .NUM_ROWS    (4),
        .FIFO_DEPTH  (4)
    ) dut_b (
        .clock        (clock),
        .reset        (reset),
        .frame_start  (fs_b),
        .solver_valid (v_b),
        .solver_data  (d_b),
        .solver_done  (done_b),
        .mem          (if_b),
        .overflow     (ov_b),
        .frame_done   (fd_b)
`ifdef PIXEL_COLLECTOR_STATS_EN
        ,
        .pixel_count  (pc_b),
        .drop_count   (dc_b)
`endif
    );

    // Record each write that will be accepted at the coming rising edge.
    always begin
        @(negedge clock);
        #2;
        if (if_a.mem_we && if_a.mem_ready)
            obs_a.push_back({if_a.mem_addr, if_a.mem_data});
        if (if_b.mem_we && if_b.mem_ready)
            obs_b.push_back({if_b.mem_addr, if_b.mem_data});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] pix_addr(int i, int k, int ns, int nc);
        return 19'((i + ns * (k / nc)) * nc + (k % nc));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0]  dv [6];
        logic [3:0]  dx, dd0, dd1;
        logic [22:0] e, x;
        int          k0, k1, acc0, acc1, s;

        reset = 1'b1;
        fs_a = 0; fs_b = 0; v_a = 0; v_b = 0;
        d_a = 0; d_b = 0; done_a = 0; done_b = 0;
        if_a.mem_ready = 0;
        if_b.mem_ready = 0;
        repeat (2) @(negedge clock);
        chk("rst_we_a", if_a.mem_we, 0);
        chk("rst_addr_a", if_a.mem_addr, 0);
        chk("rst_data_a", if_a.mem_data, 0);
        chk("rst_ovf_a", ov_a, 0);
        chk("rst_fd_a", fd_a, 0);
        chk("rst_we_b", if_b.mem_we, 0);
        chk("rst_fd_b", fd_b, 0);
`ifdef PIXEL_COLLECTOR_STATS_EN
        chk("rst_pc_a", pc_a, 0);
        chk("rst_dc_a", dc_a, 0);
`endif
        reset = 1'b0;

        // Single solver, 4x2 frame, spaced pulses, always ready.
        if_a.mem_ready = 1;
        for (int k = 0; k < 8; k++) begin
            dd0 = 4'($urandom);
            v_a = 1; d_a = dd0;
            @(negedge clock);
            v_a = 0;
            chk("A_lat_lo", if_a.mem_we, 0);
            @(negedge clock);
            chk("A_we", if_a.mem_we, 1);
            chk("A_addr", if_a.mem_addr, pix_addr(0, k, 1, 4));
            chk("A_data", if_a.mem_data, dd0);
            @(negedge clock);
            chk("A_we_lo", if_a.mem_we, 0);
        end
        chk("A_fd_pre", fd_a, 0);
        done_a = 1;
        @(negedge clock);
        chk("A_fd", fd_a, 1);
        // One pulse beyond the last row.
        v_a = 1; d_a = 4'h5;
        @(negedge clock);
        v_a = 0;
        for (int c = 0; c < 3; c++) begin
            chk("A_extra_we", if_a.mem_we, 0);
            chk("A_extra_ovf", ov_a, 0);
            @(negedge clock);
        end

        // Two solvers, 4x4 frame, simultaneous pulses.
        if_b.mem_ready = 1;
        obs_b.delete();
        exp0.delete();
        for (int k = 0; k < 8; k++) begin
            dd0 = 4'($urandom);
            dd1 = 4'($urandom);
            v_b = 2'b11; d_b = {dd1, dd0};
            exp0.push_back({pix_addr(0, k, 2, 4), dd0});
            exp0.push_back({pix_addr(1, k, 2, 4), dd1});
            @(negedge clock);
            v_b = 0;
            @(negedge clock);
        end
        repeat (4) @(negedge clock);
        chk("B_count", obs_b.size(), 16);
        for (int j = 0; j < 16; j++) begin
            e = (j < obs_b.size()) ? obs_b[j] : '1;
            chk("B_order", e, exp0[j]);
        end
        chk("B_ovf", ov_b, 0);
        done_b = 2'b11;
        repeat (2) @(negedge clock);
        chk("B_fd", fd_b, 1);

        // Stalled memory: six back-to-back pulses into depth 4.
        done_a = 0; if_a.mem_ready = 0;
        fs_a = 1;
        @(negedge clock);
        fs_a = 0;
        chk("C_fd_clr", fd_a, 0);
        obs_a.delete();
        for (int c = 0; c < 6; c++) dv[c] = 4'($urandom);
        for (int c = 0; c < 10; c++) begin
            if (c >= 2) begin
                chk("C_hold_we", if_a.mem_we, 1);
                chk("C_hold_addr", if_a.mem_addr, 0);
                chk("C_hold_data", if_a.mem_data, dv[0]);
            end
            v_a = (c < 6) ? 1'b1 : 1'b0;
            d_a = (c < 6) ? dv[c] : 4'h0;
            @(negedge clock);
        end
        chk("C_ovf", ov_a, 1);
        chk("C_no_write", obs_a.size(), 0);
        if_a.mem_ready = 1;
        repeat (8) @(negedge clock);
        chk("C_drain_cnt", obs_a.size(), 5);
        for (int j = 0; j < 5; j++) begin
            e = (j < obs_a.size()) ? obs_a[j] : '1;
            chk("C_drain", e, {pix_addr(0, j, 1, 4), dv[j]});
        end
`ifdef PIXEL_COLLECTOR_STATS_EN
        chk("C_pixel_count", pc_a, 5);
        chk("C_drop_count", dc_a, 1);
`endif
        obs_a.delete();
        dx = 4'($urandom);
        v_a = 1; d_a = dx;
        @(negedge clock);
        v_a = 0;
        repeat (4) @(negedge clock);
        chk("C_skip_cnt", obs_a.size(), 1);
        e = (obs_a.size() > 0) ? obs_a[0] : '1;
        chk("C_skip", e, {pix_addr(0, 6, 1, 4), dx});
        chk("C_ovf_sticky", ov_a, 1);

        // frame_start while a write is pending.
        if_a.mem_ready = 0;
        fs_a = 1;
        @(negedge clock);
        fs_a = 0;
        for (int c = 0; c < 2; c++) begin
            v_a = 1; d_a = 4'(c + 3);
            @(negedge clock);
        end
        v_a = 0;
        for (int n = 0; n < 10 && !if_a.mem_we; n++) @(negedge clock);
        chk("D_we_up", if_a.mem_we, 1);
        fs_a = 1;
        @(negedge clock);
        fs_a = 0;
        chk("D_we_clr", if_a.mem_we, 0);
        chk("D_ovf_clr", ov_a, 0);
        chk("D_fd_clr", fd_a, 0);
        obs_a.delete();
        if_a.mem_ready = 1;
        repeat (4) @(negedge clock);
        chk("D_fifo_empty", obs_a.size(), 0);
        dx = 4'($urandom);
        v_a = 1; d_a = dx;
        @(negedge clock);
        v_a = 0;
        repeat (4) @(negedge clock);
        chk("D_restart_cnt", obs_a.size(), 1);
        e = (obs_a.size() > 0) ? obs_a[0] : '1;
        chk("D_restart", e, {pix_addr(0, 0, 1, 4), dx});

        // Randomized frames on the two-solver build.
        for (int f = 0; f < 3; f++) begin
            done_b = 0; v_b = 0;
            fs_b = 1;
            @(negedge clock);
            fs_b = 0;
            obs_b.delete(); exp0.delete(); exp1.delete();
            k0 = 0; k1 = 0; acc0 = 0; acc1 = 0;
            for (int cyc = 0; cyc < 600; cyc++) begin
                while (obs_b.size() > 0) begin
                    e = obs_b.pop_front();
                    s = (int'(e[22:4]) / 4) % 2;
                    if (s == 0) begin
                        x = (exp0.size() > 0) ? exp0.pop_front() : '1;
                        chk("R_s0", e, x);
                        acc0++;
                    end else begin
                        x = (exp1.size() > 0) ? exp1.pop_front() : '1;
                        chk("R_s1", e, x);
                        acc1++;
                    end
                end
                if (k0 == 8 && k1 == 8 && exp0.size() == 0 &&
                    exp1.size() == 0) break;
                if_b.mem_ready = ($urandom_range(3) != 0);
                v_b = 0;
                if (k0 < 8 && (k0 - acc0) < 4 && $urandom_range(2) == 0) begin
                    dd0 = 4'($urandom);
                    v_b[0] = 1; d_b[3:0] = dd0;
                    exp0.push_back({pix_addr(0, k0, 2, 4), dd0});
                    k0++;
                end
                if (k1 < 8 && (k1 - acc1) < 4 && $urandom_range(2) == 0) begin
                    dd1 = 4'($urandom);
                    v_b[1] = 1; d_b[7:4] = dd1;
                    exp1.push_back({pix_addr(1, k1, 2, 4), dd1});
                    k1++;
                end
                @(negedge clock);
            end
            v_b = 0;
            chk("R_all_written", acc0 + acc1, 16);
            chk("R_fd_pre", fd_b, 0);
            done_b = 2'b11;
            repeat (2) @(negedge clock);
            chk("R_fd", fd_b, 1);
            chk("R_ovf", ov_b, 0);
`ifdef PIXEL_COLLECTOR_STATS_EN
            chk("R_pixel_count", pc_b, 16);
            chk("R_drop_count", dc_b, 0);
`endif
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
